pipeline_hazard_controller: RTL and testbench

Sequences stalls, bubbles, flushes and freezes for the five-stage pipeline. It sits beside the EX-stage forwarding logic. It covers the hazards forwarding cannot resolve:
- load-use dependencies (stall IF/ID, bubble ID/EX);
- taken branches resolved in ID (flush IF/ID);
- multi-cycle data-memory accesses (freeze the whole pipe, with a timeout watchdog).

It also keeps saturating performance counters for each event class.

---
 rtl/pipeline_hazard_controller.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the five-stage pipeline: load-use stalls, branch flushes,
// data-memory freezes with a timeout watchdog, and saturating event counters.
module pipeline_hazard_controller #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic [4:0]       IDEX_Rt,
  input  logic             IDEX_MemRead,
  input  logic             Branch_Taken,
  input  logic             mem_busy,
  input  logic             cnt_clear,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             Pipe_Freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mw_cnt,
  output logic [CNT_W-1:0] fl_cnt
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_next_wait;
  logic [CNT_W-1:0]    r_lu_cnt;
  logic [CNT_W-1:0]    r_mw_cnt;
  logic [CNT_W-1:0]    r_fl_cnt;
  logic                w_load_use;
  logic                w_lu_evt;
  logic                w_mw_evt;
  logic                w_fl_evt;

  assign w_load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  // Next-state, wait counter and zero-latency pipeline controls
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    PC_Write     = 1'b0;
    IFID_Write   = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    Pipe_Freeze  = 1'b0;
    w_lu_evt     = 1'b0;
    w_mw_evt     = 1'b0;
    w_fl_evt     = 1'b0;

    if (r_state == TIMEOUT) begin
      Pipe_Freeze = 1'b1;
    end else begin
      if (mem_busy) begin
        Pipe_Freeze = 1'b1;
        w_mw_evt    = 1'b1;
      end else if (w_load_use) begin
        IDEX_Bubble = 1'b1;
        w_lu_evt    = 1'b1;
      end else if (Branch_Taken) begin
        IFID_Flush  = 1'b1;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        w_fl_evt    = 1'b1;
      end else begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
      end

      // An unused encoding falls back through the RUN branch
      if (r_state == MEM_WAIT) begin
        if (!mem_busy) begin
          w_next_state = RUN;
          w_next_wait  = '0;
        end else if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
          w_next_state = TIMEOUT;
        end else begin
          w_next_wait  = r_wait_cnt + WAIT_W'(1);
        end
      end else begin
        w_next_state = mem_busy ? MEM_WAIT : RUN;
        w_next_wait  = mem_busy ? WAIT_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
    end
  end

  // Saturating counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      if (w_lu_evt && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + CNT_W'(1);
      if (w_mw_evt && (r_mw_cnt != '1)) r_mw_cnt <= r_mw_cnt + CNT_W'(1);
      if (w_fl_evt && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + CNT_W'(1);
    end
  end

  assign mem_timeout = (r_state == TIMEOUT);
  assign lu_cnt      = r_lu_cnt;
  assign mw_cnt      = r_mw_cnt;
  assign fl_cnt      = r_fl_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MAX_WAIT=4, CNT_W=4).
module tb_pipeline_hazard_controller;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 4;

  // ctrl bits: PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, mem_timeout
  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_FLUSH  = 6'b111000;
  localparam logic [5:0] C_FREEZE = 6'b000010;
  localparam logic [5:0] C_TMO    = 6'b000011;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       IFID_Rs, IFID_Rt, IDEX_Rt;
  logic             IFID_UsesRt, IDEX_MemRead, Branch_Taken, mem_busy, cnt_clear;
  logic             PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, mem_timeout;
  logic [CNT_W-1:0] lu_cnt, mw_cnt, fl_cnt;
  logic [5:0]       ctrl;

  int checks = 0;
  int errors = 0;

  assign ctrl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze, mem_timeout};

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_Rt(IDEX_Rt), .IDEX_MemRead(IDEX_MemRead),
    .Branch_Taken(Branch_Taken), .mem_busy(mem_busy), .cnt_clear(cnt_clear),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .Pipe_Freeze(Pipe_Freeze), .mem_timeout(mem_timeout),
    .lu_cnt(lu_cnt), .mw_cnt(mw_cnt), .fl_cnt(fl_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0; IDEX_Rt = 5'd0;
    IDEX_MemRead = 1'b0; Branch_Taken = 1'b0; mem_busy = 1'b0; cnt_clear = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("reset_ctrl", 32'(ctrl), 32'(C_RUN));
    check("reset_lu", 32'(lu_cnt), 0);
    check("reset_mw", 32'(mw_cnt), 0);
    check("reset_fl", 32'(fl_cnt), 0);
    check("reset_wait", 32'(dut.r_wait_cnt), 0);

    // Load-use on rs: one stall cycle, then the bubble has cleared MemRead
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
    #1 check("lu_rs_stall", 32'(ctrl), 32'(C_STALL));
    cyc();
    IDEX_MemRead = 1'b0;
    #1 check("lu_rs_after", 32'(ctrl), 32'(C_RUN));
    check("lu_cnt_1", 32'(lu_cnt), 1);

    // Destination r0 never stalls
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    #1 check("lu_r0", 32'(ctrl), 32'(C_RUN));
    cyc();
    check("lu_cnt_r0", 32'(lu_cnt), 1);

    // rt match only counts when rt is a source
    IDEX_Rt = 5'd5; IFID_Rs = 5'd3; IFID_Rt = 5'd5; IFID_UsesRt = 1'b0;
    #1 check("lu_rt_unused", 32'(ctrl), 32'(C_RUN));
    IFID_UsesRt = 1'b1;
    #1 check("lu_rt_used", 32'(ctrl), 32'(C_STALL));
    cyc();
    idle();
    #1 check("lu_cnt_2", 32'(lu_cnt), 2);

    // Branch coincident with load-use: bubble wins, flush follows next cycle
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd7; IFID_Rs = 5'd7; Branch_Taken = 1'b1;
    #1 check("br_lu_same", 32'(ctrl), 32'(C_STALL));
    cyc();
    IDEX_MemRead = 1'b0;
    #1 check("br_flush", 32'(ctrl), 32'(C_FLUSH));
    cyc();
    Branch_Taken = 1'b0;
    #1 check("br_after", 32'(ctrl), 32'(C_RUN));
    check("fl_cnt_1", 32'(fl_cnt), 1);
    check("lu_cnt_3", 32'(lu_cnt), 3);

    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    #1 check("clear_lu", 32'(lu_cnt), 0);
    check("clear_fl", 32'(fl_cnt), 0);

    // 3-cycle mem_busy over a pending load-use
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9; mem_busy = 1'b1;
    #1 check("mw_c1", 32'(ctrl), 32'(C_FREEZE));
    cyc();
    #1 check("mw_c2", 32'(ctrl), 32'(C_FREEZE));
    check("mw_wait_1", 32'(dut.r_wait_cnt), 1);
    cyc();
    #1 check("mw_c3", 32'(ctrl), 32'(C_FREEZE));
    check("mw_wait_2", 32'(dut.r_wait_cnt), 2);
    cyc();
    mem_busy = 1'b0;
    #1 check("mw_bubble", 32'(ctrl), 32'(C_STALL));
    check("mw_cnt_3", 32'(mw_cnt), 3);
    cyc();
    idle();
    #1 check("mw_state_run", 32'(dut.r_state), 0);
    check("mw_wait_0", 32'(dut.r_wait_cnt), 0);
    check("mw_lu_1", 32'(lu_cnt), 1);
    check("mw_ctrl_run", 32'(ctrl), 32'(C_RUN));

    // Watchdog: fourth busy edge enters TIMEOUT
    mem_busy = 1'b1;
    cyc();
    cyc();
    cyc();
    #1 check("tmo_pre", 32'(ctrl), 32'(C_FREEZE));
    cyc();
    #1 check("tmo_set", 32'(ctrl), 32'(C_TMO));
    check("tmo_mw_7", 32'(mw_cnt), 7);
    cyc();
    check("tmo_mw_excl", 32'(mw_cnt), 7);
    mem_busy = 1'b0; Branch_Taken = 1'b1;
    #1 check("tmo_sticky", 32'(ctrl), 32'(C_TMO));
    cyc();
    #1 check("tmo_hold", 32'(ctrl), 32'(C_TMO));
    check("tmo_fl_0", 32'(fl_cnt), 0);
    Branch_Taken = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 check("tmo_rst_ctrl", 32'(ctrl), 32'(C_RUN));
    check("tmo_rst_mw", 32'(mw_cnt), 0);

    // Flush counter saturation and clear priority
    Branch_Taken = 1'b1;
    repeat (20) cyc();
    check("fl_sat", 32'(fl_cnt), 15);
    cnt_clear = 1'b1;
    #1 check("fl_clr_ctrl", 32'(ctrl), 32'(C_FLUSH));
    cyc();
    cnt_clear = 1'b0;
    #1 check("fl_clr", 32'(fl_cnt), 0);
    cyc();
    Branch_Taken = 1'b0;
    #1 check("fl_resume", 32'(fl_cnt), 1);

    // Reset during the second MEM_WAIT cycle
    mem_busy = 1'b1;
    cyc();
    cyc();
    #1 check("rmw_wait_2", 32'(dut.r_wait_cnt), 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_busy = 1'b0;
    #1 check("rmw_ctrl", 32'(ctrl), 32'(C_RUN));
    check("rmw_wait", 32'(dut.r_wait_cnt), 0);
    check("rmw_lu", 32'(lu_cnt), 0);
    check("rmw_mw", 32'(mw_cnt), 0);
    check("rmw_fl", 32'(fl_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
